instr_sequencer: RTL



---
 rtl/instr_sequencer_pkg.sv | 24 ++
 rtl/instr_sequencer.sv | 91 +++++++++
 2 files changed

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared opcodes, memory-read set, FSM states and instruction field positions
package instr_sequencer_pkg;
  localparam logic [4:0] OP_NOP       = 5'd0;
  localparam logic [4:0] OP_ADD       = 5'd1;
  localparam logic [4:0] OP_JMP       = 5'd24;
  localparam logic [4:0] OP_LI        = 5'd25;
  localparam logic [4:0] OP_LM        = 5'd26;
  localparam logic [4:0] OP_STOREDM   = 5'd27;
  localparam logic [4:0] OP_LROM      = 5'd29;
  localparam logic [4:0] OP_SHOWDMSEG = 5'd30;
  localparam logic [4:0] OP_HALT      = 5'd31;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 5;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_e;
  function automatic logic is_memread(input logic [4:0] op);
    return op inside {OP_LM, OP_LROM, OP_SHOWDMSEG};
  endfunction
endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/issue controller for the 8-bit core
// Ports: clk/rst (sync, active-high); run/step control; im_addr/im_rdata ROM port;
// aluop/rd_sel/rs_sel/imm to execute; jump/en_write/en_writedm from execute;
// rf_we/dm_we gated write strobes; pc, busy, halted, retired status.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16,
  parameter int OPC_W = 5,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(31)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [OPC_W-1:0]   aluop,
  output logic [2:0]         rd_sel,
  output logic [2:0]         rs_sel,
  output logic [7:0]         imm,
  input  logic               jump,
  input  logic               en_write,
  input  logic               en_writedm,
  output logic               rf_we,
  output logic               dm_we,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        retired
);
  state_e r_state, w_next;
  logic [PC_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [15:0] r_retired;
  logic [OPC_W-1:0] w_op;
  logic w_memread, w_retire;
  assign w_op = r_ir[OPC_MSB:OPC_LSB];
  assign w_memread = is_memread(w_op);
  // memory-read ops retire from MEM, everything else from EXEC
  assign w_retire = (r_state == S_EXEC && !w_memread) || r_state == S_MEM;
  assign im_addr = r_pc;
  assign pc = r_pc;
  assign rd_sel = r_ir[RD_MSB:RD_LSB];
  assign rs_sel = r_ir[RS_MSB:RS_LSB];
  assign imm = r_ir[IMM_MSB:IMM_LSB];
  assign busy = !(r_state inside {S_IDLE, S_HALT});
  assign halted = r_state == S_HALT;
  assign retired = r_retired;
  always_comb begin
    w_next = r_state;
    aluop = '0;
    rf_we = 1'b0;
    dm_we = 1'b0;
    unique case (r_state)
      S_IDLE:   w_next = (run || step) ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      // the opcode is checked on the ROM word being latched, so halt costs no extra cycle
      S_DECODE: w_next = (im_rdata[OPC_MSB:OPC_LSB] == HALT_OPC) ? S_HALT : S_EXEC;
      S_EXEC: begin
        aluop = w_op;
        rf_we = !w_memread && en_write;
        dm_we = !w_memread && en_writedm;
        w_next = w_memread ? S_MEM : (run ? S_FETCH : S_IDLE);
      end
      S_MEM: begin
        aluop = w_op;
        rf_we = en_write;
        w_next = run ? S_FETCH : S_IDLE;
      end
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc <= '0;
      r_ir <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_ir <= im_rdata;
      if (w_retire) begin
        r_pc <= jump ? PC_W'(imm) : r_pc + 1'b1;
        if (r_retired != '1) r_retired <= r_retired + 1'b1;
      end
    end
  end
endmodule
